// File: rtl/vlin_pkg.sv
// Shared types and the fixed-point round/saturate helper for the element-wise affine unit.
package vlin_pkg;

  typedef enum logic {
    CFG_W = 1'b0,
    CFG_B = 1'b1
  } cfg_sel_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] y;
  } sat_res_t;

  // Works on 64-bit containers so one function serves any DW up to 32.
  function automatic sat_res_t sat_round(input logic signed [63:0] p,
                                         input logic signed [63:0] b,
                                         input int                 frac,
                                         input int                 dw);
    logic signed [63:0] rnd;
    logic signed [63:0] q;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    rnd   = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    q     = (p + rnd) >>> frac;
    s     = q + b;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    r.sat = 1'b0;
    r.y   = s;
    if (s > hi) begin
      r.y   = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      r.y   = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vlin_lane.sv
// One lane of the affine datapath: full-precision multiply, then round, bias add and saturate.
module vlin_lane
  import vlin_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] w_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] y_o,
  output logic                 sat_o
);

  logic signed [2*DW-1:0] p_q;
  logic signed [DW-1:0]   b_q;
  logic signed [DW-1:0]   y_q;
  logic                   sat_q;
  sat_res_t               res;
  logic                   unused_hi;

  always_comb res = sat_round(64'(p_q), 64'(b_q), FRAC, DW);

  // After saturation the bits above DW are pure sign extension.
  assign unused_hi = ^res.y[63:DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else if (en_i) begin
      p_q   <= (2*DW)'(x_i) * (2*DW)'(w_i);
      b_q   <= b_i;
      y_q   <= res.y[DW-1:0];
      sat_q <= res.sat;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/vector_linear_nlane.sv
// Element-wise affine unit y = x*W + B over LANES elements per beat, with on-chip
// weight/bias tables, burst addressing and a 3-stage pipeline under one global enable.
module vector_linear_nlane
  import vlin_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [DW-1:0]       cfg_wdata,
  output logic                cfg_err,
  input  logic [AW-1:0]       s_base,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  input  logic [LANES*DW-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [LANES*DW-1:0] m_data,
  output logic [LANES-1:0]    m_sat,
  output logic                busy
);

  logic signed [DW-1:0] w_mem [DEPTH];
  logic signed [DW-1:0] b_mem [DEPTH];

  logic          adv;
  logic          accept;
  logic          cfg_wr;
  logic          open_q, open_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] beat_addr;
  logic          v0_q, v1_q, v2_q;
  logic          l0_q, l1_q, l2_q;
  logic          cfg_err_q;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input int unsigned inc);
    logic [AW:0] s;
    s = {1'b0, a} + (AW+1)'(inc);
    if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  assign adv     = !v2_q | m_ready;
  assign s_ready = adv & !cfg_we;
  assign accept  = s_valid & s_ready;
  assign busy    = open_q | v0_q | v1_q | v2_q;
  assign cfg_wr  = cfg_we & !busy;
  assign m_valid = v2_q;
  assign m_last  = l2_q;
  assign cfg_err = cfg_err_q;

  // ptr_q holds the address of the next beat's lane 0 while a burst is open.
  assign beat_addr = open_q ? ptr_q : s_base;

  always_comb begin
    open_d = open_q;
    ptr_d  = ptr_q;
    if (accept) begin
      open_d = !s_last;
      ptr_d  = wrap_add(beat_addr, LANES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_q    <= 1'b0;
      ptr_q     <= '0;
      cfg_err_q <= 1'b0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      l0_q      <= 1'b0;
      l1_q      <= 1'b0;
      l2_q      <= 1'b0;
    end else begin
      open_q    <= open_d;
      ptr_q     <= ptr_d;
      cfg_err_q <= cfg_we & busy;
      if (adv) begin
        v0_q <= accept;
        l0_q <= accept & s_last;
        v1_q <= v0_q;
        l1_q <= l0_q;
        v2_q <= v1_q;
        l2_q <= l1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      if (cfg_sel_e'(cfg_sel) == CFG_B) b_mem[cfg_addr] <= cfg_wdata;
      else                              w_mem[cfg_addr] <= cfg_wdata;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [AW-1:0]        lane_addr;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] w_rd_q;
    logic signed [DW-1:0] b_rd_q;

    assign lane_addr = wrap_add(beat_addr, i);

    // S0: table reads and x capture, frozen together with the rest of the pipe.
    always_ff @(posedge clk) begin
      if (adv) begin
        x_q    <= s_data[i*DW +: DW];
        w_rd_q <= w_mem[lane_addr];
        b_rd_q <= b_mem[lane_addr];
      end
    end

    vlin_lane #(
      .DW   (DW),
      .FRAC (FRAC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (adv),
      .x_i   (x_q),
      .w_i   (w_rd_q),
      .b_i   (b_rd_q),
      .y_o   (m_data[i*DW +: DW]),
      .sat_o (m_sat[i])
    );
  end

endmodule

// File: tb/tb_vector_linear_nlane.sv
// Scoreboard bench for vector_linear_nlane: directed beats push expected results, a monitor pops and compares.
module tb_vector_linear_nlane;

  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_we;
  logic                cfg_sel;
  logic [AW-1:0]       cfg_addr;
  logic [DW-1:0]       cfg_wdata;
  logic                cfg_err;
  logic [AW-1:0]       s_base;
  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic [LANES*DW-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic [LANES*DW-1:0] m_data;
  logic [LANES-1:0]    m_sat;
  logic                busy;

  vector_linear_nlane #(
    .LANES (LANES),
    .DW    (DW),
    .FRAC  (FRAC),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .s_base    (s_base),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_data    (m_data),
    .m_sat     (m_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sat;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] held;
  bit          hold_v;
  exp_t        e;
  int          lat;
  int          bp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic sel, input int addr, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = AW'(addr);
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Vectors are written {lane1, lane0}.
  task automatic send_beat(input int base, input logic last, input logic [31:0] x,
                           input logic [31:0] y, input logic [1:0] sat, input bit push);
    int n = 0;
    s_valid = 1'b1;
    s_base  = AW'(base);
    s_last  = last;
    s_data  = x;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back('{data: y, sat: sat, last: last});
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (m_valid && !m_ready) begin
          chk("s_ready_in_stall", 32'(s_ready), 32'd0);
          if (hold_v) chk("stall_hold_data", m_data, held);
          held   = m_data;
          hold_v = 1'b1;
        end else begin
          hold_v = 1'b0;
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %08h expected no beat", m_data);
          end else begin
            e = sb.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_sat", 32'(m_sat), 32'(e.sat));
            chk("m_last", 32'(m_last), 32'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    s_base    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_sat", 32'(m_sat), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Tables: W = 1.0 everywhere, B = 0 except B[16..23] = address.
    for (int a = 0; a < DEPTH; a++) begin
      cfg_write(1'b0, a, 16'h0100);
      cfg_write(1'b1, a, (a >= 16 && a < 24) ? 16'(a) : 16'h0000);
    end
    cfg_write(1'b0, 1, 16'h0200);
    cfg_write(1'b0, 2, 16'hFF80);
    cfg_write(1'b0, 3, 16'h0040);
    cfg_write(1'b0, 8, 16'h7F00);
    cfg_write(1'b0, 9, 16'h8000);
    cfg_write(1'b1, 9, 16'hFF00);
    cfg_write(1'b0, 10, 16'h0080);
    cfg_write(1'b0, 11, 16'h007F);
    cfg_write(1'b0, 127, 16'h0200);
    cfg_write(1'b1, 127, 16'h0010);

    // Basic burst with latency
    send_beat(0, 1'b0, {16'h0100, 16'h0100}, {16'h0200, 16'h0100}, 2'b00, 1'b1);
    lat = 1;
    while (!m_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    send_beat(0, 1'b1, {16'h0400, 16'h0400}, {16'h0100, 16'hFE00}, 2'b00, 1'b1);
    wait_drain();

    // Saturation both directions
    send_beat(8, 1'b1, {16'h0100, 16'h0200}, {16'h8000, 16'h7FFF}, 2'b11, 1'b1);
    // Rounding half up
    send_beat(10, 1'b1, {16'h0001, 16'h0001}, {16'h0000, 16'h0001}, 2'b00, 1'b1);
    wait_drain();

    // Wrap at DEPTH
    send_beat(126, 1'b0, {16'h0300, 16'h0300}, {16'h0610, 16'h0300}, 2'b00, 1'b1);
    send_beat(0, 1'b1, {16'hFF00, 16'h0100}, {16'hFE00, 16'h0100}, 2'b00, 1'b1);
    wait_drain();

    // Backpressure: 5-cycle stall during a 4-beat burst
    fork
      begin
        send_beat(16, 1'b0, {16'h0200, 16'h0100}, {16'h0211, 16'h0110}, 2'b00, 1'b1);
        send_beat(0, 1'b0, {16'h0400, 16'h0300}, {16'h0413, 16'h0312}, 2'b00, 1'b1);
        send_beat(0, 1'b0, {16'h0600, 16'h0500}, {16'h0615, 16'h0514}, 2'b00, 1'b1);
        send_beat(0, 1'b1, {16'h0800, 16'h0700}, {16'h0817, 16'h0716}, 2'b00, 1'b1);
      end
      begin
        bp_n = 0;
        while (!m_valid && bp_n < 50) begin
          @(posedge clk);
          #1;
          bp_n++;
        end
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();
    chk("idle_after_bp", 32'(busy), 32'd0);

    // Config write and beat in the same idle cycle: write wins
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = AW'(50);
    cfg_wdata = 16'h0300;
    s_valid   = 1'b1;
    s_base    = AW'(50);
    s_last    = 1'b1;
    s_data    = {16'h0100, 16'h0100};
    @(negedge clk);
    chk("s_ready_cfg_collision", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    s_valid = 1'b0;
    send_beat(50, 1'b1, {16'h0100, 16'h0100}, {16'h0100, 16'h0300}, 2'b00, 1'b1);
    wait_drain();

    // Config write while busy is dropped and flagged once
    send_beat(30, 1'b0, {16'h0100, 16'h0100}, {16'h0100, 16'h0100}, 2'b00, 1'b1);
    cfg_we    = 1'b1;
    cfg_sel   = 1'b0;
    cfg_addr  = AW'(30);
    cfg_wdata = 16'h0400;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(posedge clk);
    #1;
    chk("cfg_err_single", 32'(cfg_err), 32'd0);
    send_beat(0, 1'b1, {16'h0100, 16'h0100}, {16'h0100, 16'h0100}, 2'b00, 1'b1);
    wait_drain();
    chk("busy_closed", 32'(busy), 32'd0);
    send_beat(30, 1'b1, {16'h0100, 16'h0100}, {16'h0100, 16'h0100}, 2'b00, 1'b1);
    wait_drain();

    // Reset mid-burst discards everything in flight
    send_beat(40, 1'b0, {16'h0100, 16'h0100}, 32'd0, 2'b00, 1'b0);
    send_beat(0, 1'b0, {16'h0100, 16'h0100}, 32'd0, 2'b00, 1'b0);
    send_beat(0, 1'b0, {16'h0100, 16'h0100}, 32'd0, 2'b00, 1'b0);
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // New burst must resample base rather than continue the abandoned one
    send_beat(0, 1'b1, {16'h0100, 16'h0100}, {16'h0200, 16'h0100}, 2'b00, 1'b1);
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
